// File: rtl/cavlc_pkg.sv
// Shared types and constants for the CAVLC level-encoding controller.
package cavlc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_LVL,
    S_CALC,
    S_PFX_RST,
    S_PFX_CALC,
    S_PFX_OUT,
    S_ESC_PFX,
    S_SUFFIX,
    S_UPDATE
  } lc_state_t;

  typedef enum logic {
    PATH_NORMAL,
    PATH_ESCAPE
  } lc_path_t;

  localparam int unsigned PFX_ESC14    = 14;
  localparam int unsigned PFX_ESC15    = 15;
  localparam int unsigned ESC_SUFFIX_W = 12;
  localparam int unsigned SL_MAX       = 6;

endpackage

// File: rtl/level_code_calc.sv
// Combinational evaluation of one level: level_code, path choice, escape
// prefix, suffix value/width, next suffix_len and overflow.
module level_code_calc
  import cavlc_pkg::*;
#(
  parameter int unsigned data_length = 9,
  parameter int unsigned lvl_w       = 12
) (
  input  logic [lvl_w-1:0]        i_level,
  input  logic                    i_first,
  input  logic [2:0]              i_suffix_len,
  output logic [data_length:0]    o_level_code,
  output lc_path_t                o_path,
  output logic [3:0]              o_esc_prefix,
  output logic [ESC_SUFFIX_W-1:0] o_suffix_val,
  output logic [3:0]              o_suffix_w,
  output logic [2:0]              o_next_suffix_len,
  output logic                    o_overflow
);

  localparam int unsigned DW = data_length + 1;
  localparam int unsigned CW = lvl_w + 2;
  localparam int unsigned SW = ESC_SUFFIX_W;

  logic [lvl_w:0] w_ext;
  logic [lvl_w:0] w_abs;
  logic [lvl_w:0] w_thresh;
  logic [CW-1:0]  w_raw;
  logic [DW-1:0]  w_code;
  logic [DW-1:0]  w_hi;
  logic [DW-1:0]  w_mask;
  logic [2:0]     w_sl1;

  always_comb begin
    w_ext  = {i_level[lvl_w-1], i_level};
    w_abs  = w_ext[lvl_w] ? (~w_ext + (lvl_w+1)'(1)) : w_ext;
    // Full-precision code; bits above DW flag overflow, the low DW bits carry on.
    w_raw  = {w_abs, 1'b0} - (w_ext[lvl_w] ? CW'(1) : CW'(2))
                           - (i_first ? CW'(2) : CW'(0));
    o_overflow   = |w_raw[CW-1:DW];
    w_code       = w_raw[DW-1:0];
    o_level_code = w_code;
    w_hi         = w_code >> i_suffix_len;
    w_mask       = (DW'(1) << i_suffix_len) - DW'(1);

    o_path       = PATH_NORMAL;
    o_esc_prefix = 4'(PFX_ESC14);
    o_suffix_w   = {1'b0, i_suffix_len};
    o_suffix_val = SW'(w_code & w_mask);

    if (w_hi >= DW'(PFX_ESC14)) begin
      o_path = PATH_ESCAPE;
      if (i_suffix_len == 3'd0 && w_code < DW'(30)) begin
        o_suffix_w   = 4'd4;
        o_suffix_val = SW'(w_code - DW'(PFX_ESC14));
      end else if (i_suffix_len == 3'd0 || w_hi != DW'(PFX_ESC14)) begin
        o_esc_prefix = 4'(PFX_ESC15);
        o_suffix_w   = 4'(ESC_SUFFIX_W);
        o_suffix_val = (i_suffix_len == 3'd0) ? SW'(w_code) - SW'(30)
                                              : SW'(w_code) - (SW'(PFX_ESC15) << i_suffix_len);
      end
    end

    w_sl1             = (i_suffix_len == 3'd0) ? 3'd1 : i_suffix_len;
    w_thresh          = (lvl_w+1)'(3) << (w_sl1 - 3'd1);
    o_next_suffix_len = (w_abs > w_thresh && w_sl1 < 3'(SL_MAX)) ? w_sl1 + 3'd1 : w_sl1;
  end

endmodule

// File: rtl/level_code_ctrl.sv
// CAVLC level controller: sequences Prefix_Calc for normal levels and emits
// escape prefixes and all suffix bits onto the shared 1-bit push stream.
module level_code_ctrl
  import cavlc_pkg::*;
#(
  parameter int unsigned data_length = 9,
  parameter int unsigned lvl_w       = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   blk_start,
  input  logic [4:0]             total_coeff,
  input  logic [1:0]             trailing_ones,
  input  logic                   lvl_valid,
  input  logic [lvl_w-1:0]       lvl_data,
  input  logic                   lvl_last,
  output logic                   lvl_ready,
  output logic                   pfx_rst,
  output logic                   pfx_start,
  output logic                   pfx_start_output,
  output logic [data_length:0]   pfx_level_code,
  output logic [2:0]             pfx_suffix_len,
  input  logic                   pfx_finish,
  input  logic                   pfx_fifo_push,
  input  logic                   pfx_fifo_data,
  output logic                   fifo_push,
  output logic                   fifo_data,
  output logic                   blk_done,
  output logic                   err
);

  lc_state_t                 r_state;
  lc_state_t                 w_next;
  logic [lvl_w-1:0]          r_level;
  logic                      r_last;
  logic                      r_first;
  logic [2:0]                r_sl;
  logic [3:0]                r_cnt;
  logic                      r_seen;
  logic                      r_err;
  logic [data_length:0]      r_pfx_code;
  logic [2:0]                r_pfx_sl;

  logic [data_length:0]      w_code;
  lc_path_t                  w_path;
  logic [3:0]                w_esc_pfx;
  logic [ESC_SUFFIX_W-1:0]   w_sfx_val;
  logic [3:0]                w_sfx_w;
  logic [2:0]                w_next_sl;
  logic                      w_ovf;
  logic                      w_esc_last;

  level_code_calc #(
    .data_length (data_length),
    .lvl_w       (lvl_w)
  ) u_calc (
    .i_level           (r_level),
    .i_first           (r_first),
    .i_suffix_len      (r_sl),
    .o_level_code      (w_code),
    .o_path            (w_path),
    .o_esc_prefix      (w_esc_pfx),
    .o_suffix_val      (w_sfx_val),
    .o_suffix_w        (w_sfx_w),
    .o_next_suffix_len (w_next_sl),
    .o_overflow        (w_ovf)
  );

  assign pfx_level_code = r_pfx_code;
  assign pfx_suffix_len = r_pfx_sl;
  assign err            = r_err;
  assign w_esc_last     = (r_cnt == w_esc_pfx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    lvl_ready        = 1'b0;
    pfx_rst          = 1'b1;
    pfx_start        = 1'b0;
    pfx_start_output = 1'b0;
    fifo_push        = 1'b0;
    fifo_data        = 1'b0;
    blk_done         = 1'b0;
    case (r_state)
      S_IDLE:     if (blk_start) w_next = S_WAIT_LVL;
      S_WAIT_LVL: begin
        lvl_ready = 1'b1;
        if (lvl_valid) w_next = S_CALC;
      end
      S_CALC:     w_next = (w_path == PATH_NORMAL) ? S_PFX_RST : S_ESC_PFX;
      S_PFX_RST:  begin
        pfx_rst = 1'b0;
        w_next  = S_PFX_CALC;
      end
      S_PFX_CALC: begin
        pfx_start = 1'b1;
        if (pfx_finish) w_next = S_PFX_OUT;
      end
      S_PFX_OUT:  begin
        pfx_start_output = 1'b1;
        fifo_push        = pfx_fifo_push;
        fifo_data        = pfx_fifo_data;
        // A push in the finishing cycle itself counts as observed.
        if (pfx_finish && (r_seen || pfx_fifo_push))
          w_next = (r_sl == 3'd0) ? S_UPDATE : S_SUFFIX;
      end
      S_ESC_PFX:  begin
        fifo_push = 1'b1;
        fifo_data = w_esc_last;
        if (w_esc_last) w_next = S_SUFFIX;
      end
      S_SUFFIX:   begin
        fifo_push = 1'b1;
        fifo_data = w_sfx_val[r_cnt];
        if (r_cnt == 4'd0) w_next = S_UPDATE;
      end
      S_UPDATE:   begin
        blk_done = r_last;
        w_next   = r_last ? S_IDLE : S_WAIT_LVL;
      end
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level    <= '0;
      r_last     <= 1'b0;
      r_first    <= 1'b0;
      r_sl       <= '0;
      r_cnt      <= '0;
      r_seen     <= 1'b0;
      r_err      <= 1'b0;
      r_pfx_code <= '0;
      r_pfx_sl   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (blk_start) begin
          r_sl    <= (total_coeff > 5'd10 && trailing_ones < 2'd3) ? 3'd1 : 3'd0;
          r_first <= (trailing_ones < 2'd3);
        end
        S_WAIT_LVL: if (lvl_valid) begin
          r_level <= lvl_data;
          r_last  <= lvl_last;
        end
        S_CALC: begin
          r_err      <= r_err | w_ovf;
          r_pfx_code <= w_code;
          r_pfx_sl   <= r_sl;
          r_cnt      <= '0;
        end
        S_PFX_RST: r_seen <= 1'b0;
        S_PFX_OUT: begin
          r_seen <= r_seen | pfx_fifo_push;
          r_cnt  <= w_sfx_w - 4'd1;
        end
        S_ESC_PFX: r_cnt <= w_esc_last ? w_sfx_w - 4'd1 : r_cnt + 4'd1;
        S_SUFFIX:  r_cnt <= r_cnt - 4'd1;
        S_UPDATE: begin
          r_first <= 1'b0;
          r_sl    <= w_next_sl;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_level_code_ctrl.sv
// Bench for level_code_ctrl: Prefix_Calc responder, bit-stream reference model
// built from the level-coding rules, directed literal cases plus random blocks.
module tb_level_code_ctrl;

  localparam int DL = 9;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          blk_start = 1'b0;
  logic [4:0]    total_coeff = '0;
  logic [1:0]    trailing_ones = '0;
  logic          lvl_valid = 1'b0;
  logic [LW-1:0] lvl_data = '0;
  logic          lvl_last = 1'b0;
  logic          lvl_ready, pfx_rst, pfx_start, pfx_start_output;
  logic [DL:0]   pfx_level_code;
  logic [2:0]    pfx_suffix_len;
  logic          pfx_finish = 1'b0;
  logic          pfx_fifo_push = 1'b0;
  logic          pfx_fifo_data = 1'b0;
  logic          fifo_push, fifo_data, blk_done, err;

  level_code_ctrl #(.data_length(DL), .lvl_w(LW)) dut (
    .clk(clk), .rst(rst_n), .blk_start(blk_start), .total_coeff(total_coeff),
    .trailing_ones(trailing_ones), .lvl_valid(lvl_valid), .lvl_data(lvl_data),
    .lvl_last(lvl_last), .lvl_ready(lvl_ready), .pfx_rst(pfx_rst),
    .pfx_start(pfx_start), .pfx_start_output(pfx_start_output),
    .pfx_level_code(pfx_level_code), .pfx_suffix_len(pfx_suffix_len),
    .pfx_finish(pfx_finish), .pfx_fifo_push(pfx_fifo_push),
    .pfx_fifo_data(pfx_fifo_data), .fifo_push(fifo_push), .fifo_data(fifo_data),
    .blk_done(blk_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int  exp_q[$];
  int  pfx_q[$];
  int  m_sl;
  bit  m_first;
  bit  m_err = 1'b0;
  int  blk_pending = 0;
  logic [63:0] cap = '0;
  int  cap_n = 0;
  int  last_push_cyc = 0;
  int  done_cyc = 0;
  bit  prev_done = 1'b0;

  int pf_rem = 0, pf_dly = 0, pf_str = 0;
  int pf_dly_max = 0, pf_str_lo = 0, pf_str_hi = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: bit sequence of one level from the level_code/escape rules.
  function automatic void model_level(int lvl);
    int a, code, pfx, w, val;
    a    = (lvl < 0) ? -lvl : lvl;
    code = (lvl > 0) ? 2 * lvl - 2 : 2 * a - 1;
    if (m_first) code -= 2;
    if (code >= 1024) m_err = 1'b1;
    code = code % 1024;
    if ((code >> m_sl) < 14) begin
      pfx_q.push_back(code * 8 + m_sl);
      pfx = code >> m_sl; w = m_sl; val = code % (1 << m_sl);
    end else if (m_sl == 0 && code < 30) begin
      pfx = 14; w = 4; val = code - 14;
    end else if (m_sl > 0 && (code >> m_sl) == 14) begin
      pfx = 14; w = m_sl; val = code % (1 << m_sl);
    end else begin
      pfx = 15; w = 12; val = (m_sl == 0) ? code - 30 : code - (15 << m_sl);
    end
    for (int i = 0; i < pfx; i++) exp_q.push_back(0);
    exp_q.push_back(1);
    for (int i = w - 1; i >= 0; i--) exp_q.push_back((val >> i) & 1);
    m_first = 1'b0;
    if (m_sl == 0) m_sl = 1;
    if (a > (3 << (m_sl - 1)) && m_sl < 6) m_sl++;
  endfunction

  // Prefix_Calc stand-in: unary prefix (code>>sl) zeros then a 1; noise when idle.
  always @(posedge clk) begin
    #1;
    pfx_finish = 1'b0; pfx_fifo_push = 1'b0; pfx_fifo_data = 1'b0;
    if (!pfx_rst) begin
      pf_rem = int'(pfx_level_code >> pfx_suffix_len) + 1;
      pf_dly = $urandom_range(pf_dly_max, 0);
      pf_str = $urandom_range(pf_str_hi, pf_str_lo);
    end else if (pfx_start) begin
      if (pf_dly == 0) pfx_finish = 1'b1;
      else pf_dly--;
    end else if (pfx_start_output) begin
      if (pf_rem > 0) begin
        pfx_fifo_push = 1'b1;
        pfx_fifo_data = (pf_rem == 1);
        pf_rem--;
        if (pf_rem == 0 && pf_str == 0) pfx_finish = 1'b1;
      end else if (pf_str > 0) pf_str--;
      else pfx_finish = 1'b1;
    end else begin
      pfx_fifo_push = 1'($urandom);
      pfx_fifo_data = 1'($urandom);
      pfx_finish    = 1'($urandom);
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (!pfx_rst) begin
        if (pfx_q.size() == 0) chk("pfx_rst_unexpected", 1, 0);
        else begin
          int e;
          e = pfx_q.pop_front();
          chk("pfx_level_code", int'(pfx_level_code), e / 8);
          chk("pfx_suffix_len", int'(pfx_suffix_len), e % 8);
        end
      end
      if (pfx_start_output) chk("pfx_out_push_mux", int'(fifo_push), int'(pfx_fifo_push));
      if (fifo_push) begin
        cap = {cap[62:0], fifo_data};
        cap_n++;
        last_push_cyc = cyc;
        if (exp_q.size() == 0) chk("unexpected_push", 1, 0);
        else chk("stream_bit", int'(fifo_data), exp_q.pop_front());
      end
      if (lvl_ready) chk("ready_bits_pending", exp_q.size(), 0);
      if (blk_done) begin
        done_cyc = cyc;
        chk("done_bits_outstanding", exp_q.size(), 0);
        chk("done_expected", blk_pending, 1);
        if (blk_pending > 0) blk_pending--;
        chk("err_sticky", int'(err), int'(m_err));
        chk("done_one_cycle", int'(prev_done), 0);
      end
    end
    prev_done = blk_done;
    if (cyc > 90000) begin
      n_bad++;
      $display("FAIL watchdog: got cycle %0d, expected completion before 90000", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_lvl_ready"}, int'(lvl_ready), 0);
    chk({tag, "_pfx_rst"}, int'(pfx_rst), 1);
    chk({tag, "_pfx_start"}, int'(pfx_start), 0);
    chk({tag, "_pfx_start_output"}, int'(pfx_start_output), 0);
    chk({tag, "_pfx_level_code"}, int'(pfx_level_code), 0);
    chk({tag, "_pfx_suffix_len"}, int'(pfx_suffix_len), 0);
    chk({tag, "_fifo_push"}, int'(fifo_push), 0);
    chk({tag, "_blk_done"}, int'(blk_done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  task automatic start_block(input int tc, input int t1);
    blk_start = 1'b1; total_coeff = 5'(tc); trailing_ones = 2'(t1);
    m_sl = (tc > 10 && t1 < 3) ? 1 : 0;
    m_first = (t1 < 3);
    cap = '0; cap_n = 0;
    tick();
    blk_start = 1'b0;
  endtask

  task automatic send_level(input int lvl, input bit last, input int gap);
    int t;
    t = 0;
    while (!lvl_ready && t < 3000) begin tick(); t++; end
    if (t >= 3000) begin chk("timeout_lvl_ready", 0, 1); return; end
    repeat (gap) begin
      chk("gap_lvl_ready", int'(lvl_ready), 1);
      chk("gap_no_push", int'(fifo_push), 0);
      tick();
    end
    lvl_valid = 1'b1; lvl_data = lvl[LW-1:0]; lvl_last = last;
    tick();
    lvl_valid = 1'b0; lvl_data = LW'($urandom); lvl_last = 1'($urandom);
    model_level(lvl);
    if (last) blk_pending++;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (blk_pending > 0 && t < 3000) begin tick(); t++; end
    if (t >= 3000) begin chk("timeout_blk_done", 0, 1); blk_pending = 0; end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("reset");
    rst_n = 1'b1;
    tick();

    // tc=5 t1=3: +1 -> "1", +3 -> "0010"
    start_block(5, 3);
    send_level(1, 1'b0, 0);
    send_level(3, 1'b1, 0);
    wait_done();
    chk("t1_bits_n", cap_n, 5);
    chk("t1_bits", int'(cap[4:0]), 5'b10010);
    chk("t1_done_latency", done_cyc - last_push_cyc, 1);

    // tc=2 t1=1: +2 with first adjust -> code 0 -> "1"
    start_block(2, 1);
    send_level(2, 1'b1, 0);
    wait_done();
    chk("t2_bits_n", cap_n, 1);
    chk("t2_bits", int'(cap[0]), 1);

    // tc=11 t1=0: sl starts at 1, -2 -> code 1 -> "11"
    start_block(11, 0);
    send_level(-2, 1'b1, 0);
    wait_done();
    chk("t3_bits_n", cap_n, 2);
    chk("t3_bits", int'(cap[1:0]), 2'b11);

    // tc=4 t1=3: +8 -> code 14 -> escape 14 zeros, 1, "0000"
    start_block(4, 3);
    send_level(8, 1'b1, 0);
    wait_done();
    chk("t4_bits_n", cap_n, 19);
    chk("t4_bits", int'(cap[18:0]), 16);

    // Backpressure gaps and a stretched Prefix_Calc finish
    pf_str_lo = 5; pf_str_hi = 5;
    start_block(3, 3);
    send_level(2, 1'b0, 0);
    send_level(-3, 1'b0, 10);
    send_level(5, 1'b1, 10);
    wait_done();
    chk("bp_bits_n", cap_n, 13);
    chk("bp_bits", int'(cap[12:0]), 13'b0010011000010);
    pf_str_lo = 0; pf_str_hi = 0;

    // Async reset in the middle of the escape suffix
    start_block(4, 3);
    send_level(8, 1'b1, 0);
    begin
      int t;
      t = 0;
      while (cap_n < 16 && t < 200) begin tick(); t++; end
      if (t >= 200) chk("timeout_mid_suffix", 0, 1);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outs("midrst");
    exp_q.delete(); pfx_q.delete(); blk_pending = 0; m_err = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    start_block(5, 3);
    send_level(1, 1'b0, 0);
    send_level(3, 1'b1, 0);
    wait_done();
    chk("post_rst_bits_n", cap_n, 5);
    chk("post_rst_bits", int'(cap[4:0]), 5'b10010);

    // Random blocks against the reference model
    pf_dly_max = 3; pf_str_lo = 0; pf_str_hi = 2;
    for (int b = 0; b < 40; b++) begin
      int tc, t1, n, mag, lvl;
      tc = $urandom_range(16, 1);
      t1 = $urandom_range((tc - 1 > 3) ? 3 : tc - 1, 0);
      n  = tc - t1;
      start_block(tc, t1);
      for (int j = 0; j < n; j++) begin
        mag = ($urandom_range(15, 0) == 0) ? $urandom_range(700, 300) : $urandom_range(20, 1);
        if (j == 0 && t1 < 3 && mag < 2) mag = 2;
        lvl = $urandom_range(1, 0) ? -mag : mag;
        send_level(lvl, (j == n - 1), $urandom_range(2, 0));
      end
      wait_done();
    end

    tick(); tick();
    chk("final_bits_drained", exp_q.size(), 0);
    chk("final_pfx_drained", pfx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
